// File: rtl/wb_add_sequencer.sv
// Wishbone master that writes A, writes B and reads back A+B from the adder slave.
// Optional per-beat ack timeout is built when WB_SEQ_TIMEOUT_EN is defined.
module wb_add_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] sum_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_RD_SUM, S_DONE} state_t;

    state_t      r_state, w_nxt;
    logic [31:0] r_op_a, r_op_b, r_sum, r_adr, r_dat;
    logic        r_cyc, r_stb, r_we, r_busy, r_done, r_err;
    logic [3:0]  r_sel;
    logic        w_ack, w_tmo, w_err, w_beat_nxt;

    assign w_ack = wbm_ack_i & r_stb;

`ifdef WB_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_tmo_cnt;

    // Counter restarts on every state change, so each beat gets a fresh budget.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (w_nxt != r_state))
            r_tmo_cnt <= 8'd0;
        else if (r_stb)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end

    assign w_tmo = r_stb & (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo = 1'b0 & (TIMEOUT == 0);
`endif

    // Ack is checked before timeout so a last-cycle ack still succeeds.
    always_comb begin
        w_nxt = r_state;
        w_err = 1'b0;
        case (r_state)
            S_IDLE:   if (start_i) w_nxt = S_WR_A;
            S_WR_A:   if (w_ack) w_nxt = S_WR_B;
                      else if (w_tmo) begin w_nxt = S_DONE; w_err = 1'b1; end
            S_WR_B:   if (w_ack) w_nxt = S_RD_SUM;
                      else if (w_tmo) begin w_nxt = S_DONE; w_err = 1'b1; end
            S_RD_SUM: if (w_ack) w_nxt = S_DONE;
                      else if (w_tmo) begin w_nxt = S_DONE; w_err = 1'b1; end
            S_DONE:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    assign w_beat_nxt = (w_nxt == S_WR_A) || (w_nxt == S_WR_B) || (w_nxt == S_RD_SUM);

    // Bus outputs are computed from the next state so they are all flop outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_op_a  <= 32'd0;
            r_op_b  <= 32'd0;
            r_sum   <= 32'd0;
            r_adr   <= 32'd0;
            r_dat   <= 32'd0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (r_state == S_IDLE && start_i) begin
                r_op_a <= op_a_i;
                r_op_b <= op_b_i;
            end
            if (r_state == S_RD_SUM && w_ack)
                r_sum <= wbm_dat_i;
            r_cyc  <= w_beat_nxt;
            r_stb  <= w_beat_nxt;
            r_sel  <= w_beat_nxt ? 4'hF : 4'h0;
            r_we   <= (w_nxt == S_WR_A) || (w_nxt == S_WR_B);
            r_busy <= (w_nxt != S_IDLE);
            r_done <= (w_nxt == S_DONE);
            r_err  <= w_err;
            case (w_nxt)
                S_WR_A: begin
                    r_adr <= BASE_ADDR;
                    r_dat <= (r_state == S_IDLE) ? op_a_i : r_op_a;
                end
                S_WR_B: begin
                    r_adr <= BASE_ADDR + 32'd1;
                    r_dat <= r_op_b;
                end
                S_RD_SUM: begin
                    r_adr <= BASE_ADDR + 32'd2;
                    r_dat <= 32'd0;
                end
                default: begin
                    r_adr <= 32'd0;
                    r_dat <= 32'd0;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign sum_o     = r_sum;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
endmodule

// File: tb/tb_wb_add_sequencer.sv
// Scoreboard bench for wb_add_sequencer with a registered-ack adder slave model.
module tb_wb_add_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 16;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, err, cyc, stb, we, ack_in;
    logic [31:0] sum, adr, dat_o;
    logic [3:0]  sel;
    logic        slv_ack = 1'b0, stray_ack = 1'b0, no_rd_ack = 1'b0;
    logic [31:0] slv_dat = '0, slv_a = '0, slv_b = '0;
    int          nwait = 0, wcnt = 0, cnt = 0, t0 = 0;
    int          checks = 0, errors = 0, n_done = 0, exp_done = 0;
    logic [31:0] exp_last_sum = '0;

    typedef struct {logic [31:0] adr; logic we; logic [31:0] dat;} beat_t;
    typedef struct {logic [31:0] sum; logic err; int lat;} res_t;
    beat_t bq[$];
    res_t  rq[$];

    assign ack_in = slv_ack | stray_ack;

    wb_add_sequencer #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
        .busy_o(busy), .done_o(done), .err_o(err), .sum_o(sum),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(slv_dat), .wbm_ack_i(ack_in));

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Adder slave: registered ack after nwait wait cycles, one ack per beat.
    always @(posedge clk) begin
        if (rst) begin
            slv_ack <= 1'b0;
            wcnt    <= 0;
        end else if (stb && !slv_ack) begin
            if (wcnt == nwait && !(no_rd_ack && !we)) begin
                slv_ack <= 1'b1;
                wcnt    <= 0;
                if (we && adr == BASE)              slv_a <= dat_o;
                else if (we && adr == BASE + 32'd1) slv_b <= dat_o;
                else if (!we)                       slv_dat <= slv_a + slv_b;
            end else if (wcnt < nwait) begin
                wcnt <= wcnt + 1;
            end
        end else begin
            slv_ack <= 1'b0;
        end
    end

    // Monitor: every strobed cycle must match the head beat; done pops a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (stb) begin
                chk("sel", {28'd0, sel}, 32'hF);
                chk("cyc", {31'd0, cyc}, 32'd1);
                if (bq.size() == 0) begin
                    chk("beat_unexp", 32'd1, 32'd0);
                end else begin
                    chk("adr", adr, bq[0].adr);
                    chk("we", {31'd0, we}, {31'd0, bq[0].we});
                    chk("dat", dat_o, bq[0].dat);
                    if (ack_in) void'(bq.pop_front());
                end
            end
            if (done) begin
                n_done++;
                if (rq.size() == 0) begin
                    chk("done_unexp", 32'd1, 32'd0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    chk("sum", sum, r.sum);
                    chk("err", {31'd0, err}, {31'd0, r.err});
                    if (r.lat >= 0) chk("latency", cnt - t0, r.lat);
                end
            end else if (err) begin
                chk("err_nodone", 32'd1, 32'd0);
            end
        end
    end

    task automatic push_seq(input logic [31:0] a, input logic [31:0] b, input int lat);
        beat_t bt;
        res_t  r;
        bt.adr = BASE;         bt.we = 1'b1; bt.dat = a;     bq.push_back(bt);
        bt.adr = BASE + 32'd1; bt.we = 1'b1; bt.dat = b;     bq.push_back(bt);
        bt.adr = BASE + 32'd2; bt.we = 1'b0; bt.dat = 32'd0; bq.push_back(bt);
        r.sum = a + b; r.err = 1'b0; r.lat = lat;
        rq.push_back(r);
        exp_last_sum = a + b;
        exp_done++;
    endtask

    task automatic run_seq(input logic [31:0] a, input logic [31:0] b, input int n, input int lat);
        @(negedge clk);
        op_a = a; op_b = b; nwait = n; start = 1'b1;
        push_seq(a, b, lat);
        @(posedge clk);
        #1 t0 = cnt;
        start = 1'b0;
    endtask

    task automatic flush();
        exp_done -= rq.size();
        rq.delete();
        bq.delete();
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (rq.size() != 0 && k < budget) begin
            @(negedge clk);
            #1 k++;
        end
        if (rq.size() != 0) begin
            chk("wait_expired", 32'd1, 32'd0);
            flush();
        end
        @(negedge clk);
        #1;
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("cyc_after", {31'd0, cyc}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_sel", {28'd0, sel}, 32'd0);
        rst = 1'b0;

        // zero-wait sequence
        run_seq(32'h0000_00A5, 32'h0000_005A, 0, 6);
        chk("busy_start", {31'd0, busy}, 32'd1);
        wait_done(50);
        chk("sum_ff", sum, 32'h0000_00FF);

        // three wait states per beat, wrap-around sum
        run_seq(32'hFFFF_FFFF, 32'h0000_0002, 3, 15);
        wait_done(80);
        chk("sum_wrap", sum, 32'h0000_0001);

        // start held high: exactly two sequences
        @(negedge clk);
        op_a = 32'h0000_0010; op_b = 32'h0000_0020; nwait = 0;
        push_seq(32'h0000_0010, 32'h0000_0020, -1);
        push_seq(32'h0000_0010, 32'h0000_0020, -1);
        start = 1'b1;
        repeat (12) @(negedge clk);
        start = 1'b0;
        wait_done(50);
        repeat (10) @(negedge clk);
        chk("held_count", n_done, exp_done);

        // start pulses while busy are ignored
        run_seq(32'h0000_0100, 32'h0000_0001, 0, 6);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        wait_done(50);
        repeat (8) @(negedge clk);
        chk("busy_pulse_count", n_done, exp_done);

        // reset during WR_B: no done, outputs cleared
        run_seq(32'h0000_0011, 32'h0000_0022, 2, -1);
        begin
            int k = 0;
            while (!(stb && adr == BASE + 32'd1) && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("reach_wr_b", {31'd0, stb && adr == BASE + 32'd1}, 32'd1);
        end
        rst = 1'b1;
        flush();
        @(posedge clk);
        #1;
        chk("mid_rst_cyc", {31'd0, cyc}, 32'd0);
        chk("mid_rst_stb", {31'd0, stb}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_sum", sum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_count", n_done, exp_done);
        run_seq(32'h1234_0000, 32'h0000_5678, 1, 9);
        wait_done(60);
        chk("sum_after_rst", sum, 32'h1234_5678);

        // stray acks while idle
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_cyc", {31'd0, cyc}, 32'd0);

        // operand changes mid-sequence do not affect the result
        run_seq(32'h0000_0007, 32'h0000_0008, 1, 9);
        @(negedge clk);
        op_a = 32'hFFFF_0000; op_b = 32'h0000_FFFF;
        wait_done(60);
        chk("sum_latched", sum, 32'h0000_000F);

`ifdef WB_SEQ_TIMEOUT_EN
        // read beat never acked: abort with err, sum unchanged
        begin
            beat_t bt;
            res_t  r;
            no_rd_ack = 1'b1;
            @(negedge clk);
            op_a = 32'h0000_0003; op_b = 32'h0000_0004; nwait = 0; start = 1'b1;
            bt.adr = BASE;         bt.we = 1'b1; bt.dat = 32'h3; bq.push_back(bt);
            bt.adr = BASE + 32'd1; bt.we = 1'b1; bt.dat = 32'h4; bq.push_back(bt);
            bt.adr = BASE + 32'd2; bt.we = 1'b0; bt.dat = 32'h0; bq.push_back(bt);
            r.sum = exp_last_sum; r.err = 1'b1; r.lat = 4 + TMO;
            rq.push_back(r);
            exp_done++;
            @(posedge clk);
            #1 t0 = cnt;
            start = 1'b0;
            wait_done(80);
            bq.delete();
            no_rd_ack = 1'b0;
            chk("sum_kept", sum, 32'h0000_000F);
        end
`endif

        chk("done_total", n_done, exp_done);
        chk("beats_left", bq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
